// File: rtl/axi_stream_strip_header.sv
// Removes a 1..DATA_BYTE_WD byte header from each AXI-Stream packet, re-aligns the
// remaining payload onto full MSB-aligned beats and emits the header as one beat.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    err_short
);

    // Byte counts reach (DATA_BYTE_WD-1)+DATA_BYTE_WD when a last beat overflows the carry.
    localparam int CW = BYTE_CNT_WD + 2;
    localparam logic [CW-1:0]           NB_C     = CW'(DATA_BYTE_WD);
    localparam logic [CW-1:0]           ONE_C    = CW'(1);
    localparam logic [DATA_BYTE_WD-1:0] ALL_KEEP = '1;

    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [BYTE_CNT_WD-1:0]  cnt_r;
    logic [DATA_WD-1:0]      carry_r;
    logic [DATA_BYTE_WD-1:0] carry_keep_r;

    logic [CW-1:0]      n_bytes;
    logic [CW-1:0]      c_bytes;
    logic [CW-1:0]      k_bytes;
    logic [CW-1:0]      total;
    logic [CW+2:0]      sh_n;
    logic [CW+2:0]      sh_c;
    logic [DATA_WD-1:0] data_m;
    logic               accept;
    logic               strip_acc;
    logic               pay_free;
    logic               hdr_free;

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

    function automatic logic [CW-1:0] byte_count(input logic [DATA_BYTE_WD-1:0] keep);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            cnt = cnt + CW'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [CW-1:0] cnt);
        return ~(ALL_KEEP >> cnt);
    endfunction

    // n header bytes, c = DATA_BYTE_WD-n carried bytes, k valid bytes on this beat
    assign n_bytes   = CW'(cnt_r) + ONE_C;
    assign c_bytes   = NB_C - n_bytes;
    assign k_bytes   = byte_count(keep_in);
    assign total     = c_bytes + k_bytes;
    assign sh_n      = {n_bytes, 3'b000};
    assign sh_c      = {c_bytes, 3'b000};
    assign data_m    = data_in & byte_mask(keep_in);
    assign pay_free  = !valid_out || ready_out;
    assign hdr_free  = !valid_hdr || ready_hdr;
    assign accept    = valid_in && ready_in;
    assign strip_acc = valid_strip && ready_strip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (strip_acc) state_nxt = FIRST;
            FIRST: if (accept) state_nxt = last_in ? IDLE : BODY;
            BODY:  if (accept && last_in) state_nxt = (total > NB_C) ? FLUSH : IDLE;
            FLUSH: if (pay_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A single-beat packet may load both output registers, so FIRST waits for both to be free.
    always_comb begin
        ready_in    = 1'b0;
        ready_strip = 1'b0;
        case (state)
            IDLE:    ready_strip = rst_n;
            FIRST:   ready_in    = hdr_free && pay_free;
            BODY:    ready_in    = pay_free;
            default: ready_in    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            carry_r      <= '0;
            carry_keep_r <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_hdr    <= 1'b0;
            data_hdr     <= '0;
            keep_hdr     <= '0;
            err_short    <= 1'b0;
        end else begin
            err_short <= 1'b0;
            if (ready_hdr) valid_hdr <= 1'b0;
            if (ready_out) valid_out <= 1'b0;
            if (strip_acc) cnt_r <= byte_strip_cnt;

            // FIRST: split the beat into header and carried remainder
            if (state == FIRST && accept) begin
                carry_r      <= data_m << sh_n;
                carry_keep_r <= keep_in << n_bytes;
                if (last_in && (k_bytes < n_bytes)) begin
                    err_short <= 1'b1;
                end else begin
                    valid_hdr <= 1'b1;
                    data_hdr  <= data_m >> sh_c;
                    keep_hdr  <= ALL_KEEP >> c_bytes;
                    if (last_in && (k_bytes > n_bytes)) begin
                        valid_out <= 1'b1;
                        data_out  <= data_m << sh_n;
                        keep_out  <= keep_in << n_bytes;
                        last_out  <= 1'b1;
                    end
                end
            end

            // BODY: carried bytes followed by the leading bytes of the new beat
            if (state == BODY && accept) begin
                valid_out    <= 1'b1;
                data_out     <= carry_r | (data_m >> sh_c);
                carry_r      <= data_m << sh_n;
                carry_keep_r <= keep_in << n_bytes;
                if (last_in && (total <= NB_C)) begin
                    keep_out <= keep_msb(total);
                    last_out <= 1'b1;
                end else begin
                    keep_out <= ALL_KEEP;
                    last_out <= 1'b0;
                end
            end

            // FLUSH: residual bytes of an overflowing last beat
            if (state == FLUSH && pay_free) begin
                valid_out <= 1'b1;
                data_out  <= carry_r;
                keep_out  <= carry_keep_r;
                last_out  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed and randomised packets against a byte-level model of header stripping;
// expected header/payload beats are queued at stimulus time and popped on output.
module tb_axi_stream_strip_header;

    localparam int DW = 32;
    localparam int NB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
    } hdr_t;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [NB-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [NB-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
    logic          valid_strip;
    logic [1:0]    byte_strip_cnt;
    logic          ready_strip;
    logic          valid_hdr;
    logic [DW-1:0] data_hdr;
    logic [NB-1:0] keep_hdr;
    logic          ready_hdr;
    logic          err_short;

    int    n_assert;
    int    n_fail;
    int    err_seen;
    int    exp_err;
    bit    rand_ro;
    beat_t in_q[$];
    beat_t exp_pay[$];
    hdr_t  exp_hdr[$];

    axi_stream_strip_header #(.DATA_WD(DW), .DATA_BYTE_WD(NB), .BYTE_CNT_WD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
        .err_short(err_short)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = rand_ro ? (($urandom % 2) == 0) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability and err_short pulse counting
    initial begin
        logic             stall_out;
        logic             stall_hdr;
        logic [DW+NB:0]   held_out;
        logic [DW+NB-1:0] held_hdr;
        beat_t            eb;
        hdr_t             eh;
        stall_out = 1'b0;
        stall_hdr = 1'b0;
        held_out  = '0;
        held_hdr  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_out = 1'b0;
                stall_hdr = 1'b0;
            end else begin
                if (stall_out) begin
                    check("out_stall_valid", 64'(valid_out), 64'd1);
                    check("out_stall_beat", 64'({data_out, keep_out, last_out}), 64'(held_out));
                end
                if (stall_hdr) begin
                    check("hdr_stall_valid", 64'(valid_hdr), 64'd1);
                    check("hdr_stall_beat", 64'({data_hdr, keep_hdr}), 64'(held_hdr));
                end
                if (valid_out && ready_out) begin
                    n_assert++;
                    assert (exp_pay.size() != 0) else begin
                        n_fail++;
                        $error("FAIL pay_unexpected: observed %h/%b expected no beat", data_out, keep_out);
                    end
                    if (exp_pay.size() != 0) begin
                        eb = exp_pay.pop_front();
                        check("pay_beat", 64'({data_out, keep_out, last_out}), 64'(eb));
                    end
                end
                if (valid_hdr && ready_hdr) begin
                    n_assert++;
                    assert (exp_hdr.size() != 0) else begin
                        n_fail++;
                        $error("FAIL hdr_unexpected: observed %h/%b expected no header", data_hdr, keep_hdr);
                    end
                    if (exp_hdr.size() != 0) begin
                        eh = exp_hdr.pop_front();
                        check("hdr_beat", 64'({data_hdr, keep_hdr}), 64'(eh));
                    end
                end
                if (err_short) err_seen++;
                stall_out = valid_out && !ready_out;
                stall_hdr = valid_hdr && !ready_hdr;
                held_out  = {data_out, keep_out, last_out};
                held_hdr  = {data_hdr, keep_hdr};
            end
        end
    end

    task automatic strip_cmd(input int n);
        bit got;
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(n - 1);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = ready_strip;
            @(posedge clk);
            #1;
        end
        check("strip_accept", 64'(got), 64'd1);
        valid_strip = 1'b0;
    endtask

    task automatic drive_beat(input beat_t b);
        bit got;
        valid_in = 1'b1;
        data_in  = b.data;
        keep_in  = b.keep;
        last_in  = b.last;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = ready_in;
            @(posedge clk);
            #1;
        end
        check("beat_accept", 64'(got), 64'd1);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    // Byte-level model: header = first n bytes, payload = the rest packed 4 per beat
    task automatic push_expect(input int n);
        logic [7:0]    b[$];
        logic [DW-1:0] d;
        logic [NB-1:0] kp;
        beat_t         t;
        hdr_t          h;
        b = {};
        foreach (in_q[i]) begin
            t = in_q[i];
            d = t.data;
            for (int j = 0; j < NB; j++) begin
                if (t.keep[NB-1-j]) b.push_back(d[DW-1-8*j -: 8]);
            end
        end
        if (b.size() < n) begin
            exp_err++;
        end else begin
            d = '0;
            for (int i = 0; i < n; i++) d = {d[DW-9:0], b[i]};
            h.data = d;
            h.keep = 4'hF >> (NB - n);
            exp_hdr.push_back(h);
            for (int s = n; s < b.size(); s += NB) begin
                d  = '0;
                kp = '0;
                for (int j = 0; j < NB; j++) begin
                    if (s + j < b.size()) begin
                        d[DW-1-8*j -: 8] = b[s+j];
                        kp[NB-1-j] = 1'b1;
                    end
                end
                t.data = d;
                t.keep = kp;
                t.last = (s + NB >= b.size());
                exp_pay.push_back(t);
            end
        end
    endtask

    task automatic send_pkt(input int n);
        strip_cmd(n);
        push_expect(n);
        foreach (in_q[i]) drive_beat(in_q[i]);
        in_q = {};
    endtask

    task automatic add_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        beat_t t;
        t.data = d;
        t.keep = k;
        t.last = l;
        in_q.push_back(t);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 300 && (exp_pay.size() != 0 || exp_hdr.size() != 0); c++) @(posedge clk);
        #1;
        check({tag, "_pay_drained"}, 64'(exp_pay.size()), 64'd0);
        check({tag, "_hdr_drained"}, 64'(exp_hdr.size()), 64'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        err_seen = 0;
        exp_err = 0;
        rand_ro = 1'b0;
        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        keep_in = '0;
        last_in = 1'b0;
        valid_strip = 1'b0;
        byte_strip_cnt = '0;
        ready_hdr = 1'b1;

        // Reset state
        #1;
        check("rst_outputs", 64'({valid_out, last_out, valid_hdr, err_short, ready_in, ready_strip}), 64'd0);
        check("rst_data", 64'({data_out, keep_out}), 64'd0);
        check("rst_hdr", 64'({data_hdr, keep_hdr}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_ready_strip", 64'(ready_strip), 64'd1);
        check("idle_ready_in", 64'(ready_in), 64'd0);

        // n=2, three full beats
        add_beat(32'hAABBCCDD, 4'hF, 1'b0);
        add_beat(32'h11223344, 4'hF, 1'b0);
        add_beat(32'h55667788, 4'hF, 1'b1);
        send_pkt(2);
        drain("n2");

        // n=4, partial last beat
        add_beat(32'hAABBCCDD, 4'hF, 1'b0);
        add_beat(32'h11223344, 4'hC, 1'b1);
        send_pkt(4);
        drain("n4");

        // n=1, last beat overflows into FLUSH
        add_beat(32'hA0A1A2A3, 4'hF, 1'b0);
        add_beat(32'hB0B1B2B3, 4'hE, 1'b1);
        send_pkt(1);
        check("flush_ready_in", 64'(ready_in), 64'd0);
        check("flush_ready_strip", 64'(ready_strip), 64'd0);
        drain("flush");

        // Short packet
        add_beat(32'hAABB0000, 4'hC, 1'b1);
        send_pkt(4);
        repeat (3) @(posedge clk);
        #1;
        check("short_err_pulses", 64'(err_seen), 64'(exp_err));
        drain("short");
        check("short_back_idle", 64'(ready_strip), 64'd1);

        // Backpressure: random ready_out, header held off for 5 cycles
        rand_ro = 1'b1;
        ready_hdr = 1'b0;
        for (int i = 0; i < 6; i++) add_beat($urandom, (i == 5) ? 4'h8 : 4'hF, i == 5);
        fork
            send_pkt(3);
            begin
                repeat (5) @(posedge clk);
                #1;
                ready_hdr = 1'b1;
            end
        join
        drain("bp");
        rand_ro = 1'b0;

        // Reset during beat 2 of a 4-beat packet
        @(posedge clk);
        #1;
        strip_cmd(2);
        drive_beat({32'h01020304, 4'hF, 1'b0});
        check("pre_rst_hdr_valid", 64'(valid_hdr), 64'd1);
        valid_in = 1'b1;
        data_in  = 32'h05060708;
        keep_in  = 4'hF;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({valid_out, last_out, valid_hdr, err_short, ready_in, ready_strip}), 64'd0);
        check("midrst_data", 64'({data_out, keep_out, data_hdr, keep_hdr}), 64'd0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_beat(32'h10203040, 4'hF, 1'b0);
        add_beat(32'h50607080, 4'hF, 1'b0);
        add_beat(32'h90A0B0C0, 4'hF, 1'b1);
        send_pkt(3);
        drain("post_rst");

        // Random packets with random ready_out and occasional header stall
        rand_ro = 1'b1;
        for (int p = 0; p < 8; p++) begin
            int n;
            int nb;
            n  = $urandom_range(1, 4);
            nb = $urandom_range(1, 5);
            for (int i = 0; i < nb; i++) begin
                int k;
                k = (i == nb - 1) ? $urandom_range(1, 4) : 4;
                add_beat($urandom, 4'(4'hF << (4 - k)), i == nb - 1);
            end
            ready_hdr = ($urandom % 4) != 0;
            fork
                send_pkt(n);
                begin
                    repeat (3) @(posedge clk);
                    #1;
                    ready_hdr = 1'b1;
                end
            join
        end
        drain("rand");
        repeat (3) @(posedge clk);
        #1;
        check("total_err_pulses", 64'(err_seen), 64'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
